master_rr_arbiter: RTL and testbench
====================================

// Module: master_rr_arbiter
// PURPOSE
//  Clocked round-robin arbiter sharing one slave port between bus masters.
//  Drives the one-hot grant arb_master_req that selects a master in the masters mux.
//  Locks the grant for a whole transaction (request until slave_ack) and releases it on completion.
//  A watchdog releases the grant and flags an error if the slave never acknowledges.
// PARAMETERS
//  masters_number  2    number of masters; width of master_req and arb_master_req
//  TIMEOUT         16   max cycles held in GRANT without ack; 0 disables the watchdog
// PORTS
//  clk             in   1               clock, rising edge
//  rst             in   1               synchronous reset, active-low
//  master_req      in   masters_number  request per master; bit0 = master_1, bit1 = master_2
//  slave_ack       in   1               slave completion strobe, as seen by the mux
//  arb_master_req  out  masters_number  registered one-hot grant; 0 = no master
//  busy            out  1               registered; 1 while in GRANT
//  timeout_err     out  1               registered 1-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE, arb_master_req=0, busy=0, timeout_err=0, timer=0.
//   Last-granted pointer = highest index, so master_1 has first priority.
//   Applies mid-transaction too; the grant is dropped at that edge and there is no error pulse.
//  States: IDLE, GRANT.
//  IDLE:
//   - If master_req != 0, pick the winner round-robin: the first set bit after the last-granted index, wrapping.
//   - Next edge: arb_master_req <= onehot(winner), busy <= 1, pointer <= winner, timer <= 0, go to GRANT.
//   - Latency: a request sampled at edge k gives the grant visible in cycle k+1.
//   - If master_req == 0: hold IDLE, grant stays 0.
//  GRANT (grant held stable, never changes mid-transaction):
//   - slave_ack==1: next edge grant <= 0, busy <= 0, go to IDLE.
//     This forces one idle bus cycle between grants; next grant is no earlier than ack+2.
//   - Granted master deasserts its req without ack (abandon): same release as ack, no error.
//   - TIMEOUT!=0 and timer==TIMEOUT-1 with no ack: release as above and timeout_err <= 1 for one cycle.
//   - Otherwise: timer <= timer+1.
//   - Priority: ack > abandon > timeout. Ack in the same cycle as the timeout limit means no error.
//  Other requests during GRANT are ignored (not queued). They are re-evaluated in IDLE.
//  slave_ack while in IDLE is ignored.
//  timer width = $clog2(TIMEOUT+1), minimum 1. It saturates and never wraps.
//  Fairness: with both masters requesting continuously, grants alternate 01,10,01,...
//  All outputs come straight from flops; there is no combinational path input->output.
// STRUCTURE
//  Package master_arb_pkg:
//   - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t
//   - localparams NO_MASTER=2'b00, FIRST_MASTER=2'b01, SECOND_MASTER=2'b10
//  Sub-module rr_pick (combinational): inputs req vector and last-granted index;
//   outputs one-hot winner and valid. Parameterised by masters_number.
//  Top: FSM, grant register, pointer register, watchdog timer.
// TESTING
//  1 Reset: rst=0 for 2 cycles with master_req=2'b11.
//    -> arb_master_req=00, busy=0, timeout_err=0 throughout.
//  2 Single master: master_req=01 at edge 0, slave_ack at cycle 3.
//    -> grant=01 in cycles 1..3, 00 in cycle 4, busy mirrors grant.
//  3 Contention: master_req=11 held, ack 2 cycles after each grant.
//    -> grant sequence 01,00,10,00,01... (strict alternation, one idle gap).
//  4 Timeout: TIMEOUT=4, master_req=10, no ack.
//    -> grant=10 in cycles 1..4, timeout_err=1 in cycle 5 only, grant=00 in cycle 5.
//  5 Ack at the limit: TIMEOUT=4, ack in cycle 4.
//    -> release, timeout_err stays 0.
//    Abandon: master_1 drops req in cycle 2 -> grant 00 in cycle 3, no error.
//  6 Reset mid-GRANT: rst=0 in cycle 2 of grant 01.
//    -> grant=00 next edge, and after reset release with master_req=11 the first grant is 01.

Source files
------------

// File: rtl/master_arb_pkg.sv
// Shared types and constants for the round-robin slave-port arbiter.
// Grant encodings below assume the two-master configuration.
package master_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

   localparam logic [1:0] NO_MASTER     = 2'b00;
   localparam logic [1:0] FIRST_MASTER  = 2'b01;
   localparam logic [1:0] SECOND_MASTER = 2'b10;

endpackage

// File: rtl/master_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after the
// last-granted index, wrapping around.
module rr_pick #(
   parameter  int masters_number = 2,
   localparam int IW = (masters_number > 1) ? $clog2(masters_number) : 1
) (
   input  logic [masters_number-1:0] req,
   input  logic [IW-1:0]             last,
   output logic [masters_number-1:0] winner,
   output logic                      valid
);

   logic [IW-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int off = 1; off <= masters_number; off++) begin
         idx = IW'((int'(last) + off) % masters_number);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/master_rr_arbiter.sv
// Round-robin arbiter locking one slave port to a master per transaction,
// with a watchdog that releases a grant the slave never acknowledges.
module master_rr_arbiter #(
   parameter int masters_number = 2,
   parameter int TIMEOUT        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [masters_number-1:0] master_req,
   input  logic                      slave_ack,
   output logic [masters_number-1:0] arb_master_req,
   output logic                      busy,
   output logic                      timeout_err
);

   import master_arb_pkg::*;

   localparam int IW = (masters_number > 1) ? $clog2(masters_number) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_t state, state_n;
   logic [masters_number-1:0] grant_n;
   logic [masters_number-1:0] win_oh;
   logic [IW-1:0] ptr, ptr_n, win_idx;
   logic [TW-1:0] timer, timer_n;
   logic busy_n, err_n, win_vld;
   logic abandon, wd_fire;

   rr_pick #(
      .masters_number(masters_number)
   ) u_pick (
      .req    (master_req),
      .last   (ptr),
      .winner (win_oh),
      .valid  (win_vld)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < masters_number; i++) begin
         if (win_oh[i]) win_idx = IW'(i);
      end
   end

   // Owner dropping its request ends the transaction without an error.
   assign abandon = ~|(master_req & arb_master_req);
   assign wd_fire = (TIMEOUT != 0) && (timer == TLIM);

   always_comb begin
      state_n = state;
      grant_n = arb_master_req;
      busy_n  = busy;
      err_n   = 1'b0;
      timer_n = timer;
      ptr_n   = ptr;
      unique case (state)
         ARB_IDLE: begin
            if (win_vld) begin
               state_n = ARB_GRANT;
               grant_n = win_oh;
               busy_n  = 1'b1;
               ptr_n   = win_idx;
               timer_n = '0;
            end
         end
         ARB_GRANT: begin
            if (slave_ack || abandon || wd_fire) begin
               state_n = ARB_IDLE;
               grant_n = '0;
               busy_n  = 1'b0;
               err_n   = !slave_ack && !abandon;
            end else if (timer != '1) begin
               timer_n = timer + 1'b1;
            end
         end
         default: begin
            state_n = ARB_IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= ARB_IDLE;
         arb_master_req <= '0;
         busy           <= 1'b0;
         timeout_err    <= 1'b0;
         timer          <= '0;
         ptr            <= IW'(masters_number - 1);
      end else begin
         state          <= state_n;
         arb_master_req <= grant_n;
         busy           <= busy_n;
         timeout_err    <= err_n;
         timer          <= timer_n;
         ptr            <= ptr_n;
      end
   end

endmodule

// File: tb/tb_master_rr_arbiter.sv
// Scoreboard bench: directed scenarios then random traffic, each cycle's
// outputs checked against a transaction-level reference model.
module tb_master_rr_arbiter;

   import master_arb_pkg::*;

   localparam int N  = 2;
   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] master_req = '0;
   logic         slave_ack = 1'b0;
   logic [N-1:0] arb_master_req;
   logic         busy;
   logic         timeout_err;

   typedef struct {
      int         cyc;
      logic [N-1:0] grant;
      logic       busy;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   int   owner = -1;
   int   last = N - 1;
   int   cnt = 0;
   bit   err = 0;

   master_rr_arbiter #(
      .masters_number(N),
      .TIMEOUT(TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .master_req     (master_req),
      .slave_ack      (slave_ack),
      .arb_master_req (arb_master_req),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: owner of the port, last owner, cycles held so far.
   task automatic model_step(input logic r, input logic [N-1:0] req,
                             input logic ack);
      err = 0;
      if (!r) begin
         owner = -1;
         last  = N - 1;
         cnt   = 0;
      end else if (owner < 0) begin
         for (int o = 1; o <= N; o++) begin
            int c;
            c = (last + o) % N;
            if (owner < 0 && req[c]) begin
               owner = c;
               last  = c;
               cnt   = 0;
            end
         end
      end else if (ack || !req[owner]) begin
         owner = -1;
      end else if (cnt == TO - 1) begin
         owner = -1;
         err   = 1;
      end else begin
         cnt++;
      end
   endtask

   task automatic drive(input logic r, input logic [N-1:0] req,
                        input logic ack);
      exp_t e;
      @(posedge clk);
      #1;
      rst        = r;
      master_req = req;
      slave_ack  = ack;
      model_step(r, req, ack);
      e.cyc   = cyc + 1;
      e.grant = (owner < 0) ? '0 : N'(1 << owner);
      e.busy  = (owner >= 0);
      e.err   = err;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missed_check cyc=%0d expected entry never compared",
                     e.cyc);
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            n_tests++;
            if (arb_master_req !== e.grant || busy !== e.busy ||
                timeout_err !== e.err) begin
               n_fail++;
               $display("FAIL outputs cyc=%0d got grant=%b busy=%b err=%b expected grant=%b busy=%b err=%b",
                        cyc, arb_master_req, busy, timeout_err,
                        e.grant, e.busy, e.err);
            end
         end
      end
   end

   initial begin : stim
      // Reset held with both masters requesting.
      repeat (2) drive(1'b0, 2'b11, 1'b0);
      // Single master, ack in its third grant cycle.
      drive(1'b1, FIRST_MASTER, 1'b0);
      repeat (2) drive(1'b1, FIRST_MASTER, 1'b0);
      drive(1'b1, FIRST_MASTER, 1'b1);
      repeat (2) drive(1'b1, NO_MASTER, 1'b0);
      // Contention: ack in the second cycle of every grant.
      repeat (14) drive(1'b1, 2'b11, owner >= 0 && cnt == 1);
      repeat (2) drive(1'b1, NO_MASTER, 1'b0);
      // Watchdog expiry.
      repeat (7) drive(1'b1, SECOND_MASTER, 1'b0);
      repeat (2) drive(1'b1, NO_MASTER, 1'b0);
      // Ack arriving exactly at the watchdog limit.
      repeat (6) drive(1'b1, FIRST_MASTER, owner >= 0 && cnt == TO - 1);
      repeat (2) drive(1'b1, NO_MASTER, 1'b1);
      // Abandon after two grant cycles.
      repeat (2) drive(1'b1, FIRST_MASTER, 1'b0);
      repeat (2) drive(1'b1, NO_MASTER, 1'b0);
      // Reset in the middle of a grant, then contention again.
      repeat (2) drive(1'b1, FIRST_MASTER, 1'b0);
      drive(1'b0, FIRST_MASTER, 1'b0);
      repeat (4) drive(1'b1, 2'b11, 1'b0);
      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         drive(($urandom % 60) != 0, N'($urandom),
               ($urandom % 4) == 0);
      end
      drive(1'b1, NO_MASTER, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
